// File: rtl/csr_pkg.sv
// Shared CSR addresses, request opcodes, sequencer states and mstatus field positions.
package csr_pkg;

  localparam int CSR_XLEN = 32;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    OP_CSRRW = 3'd0,
    OP_CSRRS = 3'd1,
    OP_CSRRC = 3'd2,
    OP_ECALL = 3'd3,
    OP_MRET  = 3'd4
  } req_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CSR_RW = 3'd1,
    ST_TRAP   = 3'd2,
    ST_MRET   = 3'd3,
    ST_MST    = 3'd4,
    ST_DONE   = 3'd5
  } csr_state_e;

  // Trap entry stacks MIE into MPIE; return restores it. Both force machine mode into MPP.
  function automatic logic [CSR_XLEN-1:0] mstatus_next(input logic [CSR_XLEN-1:0] old,
                                                       input logic is_mret);
    logic [CSR_XLEN-1:0] v;
    v = old;
    if (is_mret) begin
      v[MSTATUS_MIE]  = old[MSTATUS_MPIE];
      v[MSTATUS_MPIE] = 1'b1;
    end else begin
      v[MSTATUS_MPIE] = old[MSTATUS_MIE];
      v[MSTATUS_MIE]  = 1'b0;
    end
    v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return v;
  endfunction

endpackage

// File: rtl/csr_trap_seq_if.sv
// Decode-side request/completion channel of the CSR trap sequencer.
interface csr_trap_seq_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [11:0]     req_csr;
  logic [XLEN-1:0] req_src;
  logic [XLEN-1:0] req_pc;
  logic            done_valid;
  logic [XLEN-1:0] done_rd_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output req_valid, req_op, req_csr, req_src, req_pc,
    input  req_ready, done_valid, done_rd_data, redirect_valid, redirect_pc
  );

  modport slave (
    input  req_valid, req_op, req_csr, req_src, req_pc,
    output req_ready, done_valid, done_rd_data, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/csr_op_alu.sv
// Read-modify-write datapath for CSRRW/CSRRS/CSRRC: new value, write-suppress and
// supported-address flags.
module csr_op_alu
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_op,
  input  logic [11:0]     i_csr,
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_src,
  output logic [XLEN-1:0] o_new,
  output logic            o_no_write,
  output logic            o_supported
);

  always_comb begin
    o_new = i_src;
    case (i_op)
      OP_CSRRS: o_new = i_old | i_src;
      OP_CSRRC: o_new = i_old & ~i_src;
      default:  o_new = i_src;
    endcase
  end

  // Set/clear with a zero mask is a pure read and must not disturb the register.
  assign o_no_write = ((i_op == OP_CSRRS) || (i_op == OP_CSRRC)) && (i_src == '0);

  assign o_supported = (i_csr == CSR_MSTATUS) || (i_csr == CSR_MTVEC) ||
                       (i_csr == CSR_MEPC)    || (i_csr == CSR_MCAUSE);

endmodule

// File: rtl/csr_trap_seq.sv
// Sequencer for CSR read-modify-write, ECALL and MRET traffic to the CSR file.
// Optional CSR_TRAP_MSTATUS_EN adds an mstatus update state after TRAP/MRET.
//
// state   | meaning
// IDLE    | ready for a request
// CSR_RW  | read old CSR, write modified value
// TRAP    | write mepc/mcause, fetch mtvec
// MRET    | fetch mepc as return target
// MST     | stack/unstack mstatus interrupt bits (macro only)
// DONE    | one-cycle completion pulse with result
module csr_trap_seq
  import csr_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] ECALL_CODE = 32'd11
) (
  input  logic              i_clk,
  input  logic              i_rst,
  csr_trap_seq_if.slave     io_dec,
  output logic              o_csr_wen,
  output logic [11:0]       o_csr_waddr1,
  output logic [11:0]       o_csr_waddr2,
  output logic [XLEN-1:0]   o_csr_wdata1,
  output logic [XLEN-1:0]   o_csr_wdata2,
  output logic [11:0]       o_csr_raddr,
  input  logic [XLEN-1:0]   i_csr_rdata
);

  csr_state_e      r_state, w_state_nxt;
  logic [2:0]      r_op;
  logic [11:0]     r_csr;
  logic [XLEN-1:0] r_src, r_pc;
  logic [XLEN-1:0] r_rd_data, r_redir_pc;
  logic            r_redir;
`ifdef CSR_TRAP_MSTATUS_EN
  logic [XLEN-1:0] r_pend_pc;
`endif

  logic            w_accept;
  logic            w_wen;
  logic [XLEN-1:0] w_res_rd, w_res_pc;
  logic            w_res_redir;
  logic [XLEN-1:0] w_alu_new;
  logic            w_alu_no_write, w_alu_supported;

  csr_op_alu #(.XLEN(XLEN)) u_alu (
    .i_op        (r_op),
    .i_csr       (r_csr),
    .i_old       (i_csr_rdata),
    .i_src       (r_src),
    .o_new       (w_alu_new),
    .o_no_write  (w_alu_no_write),
    .o_supported (w_alu_supported)
  );

  assign io_dec.req_ready = (r_state == ST_IDLE) && !i_rst;
  assign w_accept         = io_dec.req_valid && io_dec.req_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_wen        = 1'b0;
    o_csr_waddr1 = '0;
    o_csr_waddr2 = '0;
    o_csr_wdata1 = '0;
    o_csr_wdata2 = '0;
    o_csr_raddr  = '0;
    w_res_rd     = '0;
    w_res_pc     = '0;
    w_res_redir  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (io_dec.req_op)
            OP_CSRRW, OP_CSRRS, OP_CSRRC: w_state_nxt = ST_CSR_RW;
            OP_ECALL:                     w_state_nxt = ST_TRAP;
            OP_MRET:                      w_state_nxt = ST_MRET;
            default:                      w_state_nxt = ST_DONE;
          endcase
        end
      end
      ST_CSR_RW: begin
        o_csr_raddr  = r_csr;
        w_wen        = w_alu_supported && !w_alu_no_write;
        o_csr_waddr1 = r_csr;
        o_csr_waddr2 = r_csr;
        o_csr_wdata1 = w_alu_new;
        o_csr_wdata2 = w_alu_new;
        w_res_rd     = w_alu_supported ? i_csr_rdata : '0;
        w_state_nxt  = ST_DONE;
      end
      ST_TRAP: begin
        o_csr_raddr  = CSR_MTVEC;
        w_wen        = 1'b1;
        o_csr_waddr1 = CSR_MEPC;
        o_csr_wdata1 = r_pc;
        o_csr_waddr2 = CSR_MCAUSE;
        o_csr_wdata2 = ECALL_CODE;
        w_res_pc     = {i_csr_rdata[XLEN-1:2], 2'b00};
        w_res_redir  = 1'b1;
`ifdef CSR_TRAP_MSTATUS_EN
        w_state_nxt  = ST_MST;
`else
        w_state_nxt  = ST_DONE;
`endif
      end
      ST_MRET: begin
        o_csr_raddr  = CSR_MEPC;
        w_res_pc     = i_csr_rdata;
        w_res_redir  = 1'b1;
`ifdef CSR_TRAP_MSTATUS_EN
        w_state_nxt  = ST_MST;
`else
        w_state_nxt  = ST_DONE;
`endif
      end
`ifdef CSR_TRAP_MSTATUS_EN
      ST_MST: begin
        o_csr_raddr  = CSR_MSTATUS;
        w_wen        = 1'b1;
        o_csr_waddr1 = CSR_MSTATUS;
        o_csr_waddr2 = CSR_MSTATUS;
        o_csr_wdata1 = mstatus_next(i_csr_rdata, r_op == OP_MRET);
        o_csr_wdata2 = mstatus_next(i_csr_rdata, r_op == OP_MRET);
        w_res_pc     = r_pend_pc;
        w_res_redir  = 1'b1;
        w_state_nxt  = ST_DONE;
      end
`endif
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Reset mid-operation must never let a half-finished write reach the CSR file.
  assign o_csr_wen             = w_wen && !i_rst;
  assign io_dec.done_valid     = (r_state == ST_DONE) && !i_rst;
  assign io_dec.redirect_valid = (r_state == ST_DONE) && !i_rst && r_redir;
  assign io_dec.done_rd_data   = r_rd_data;
  assign io_dec.redirect_pc    = r_redir_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_op       <= '0;
      r_csr      <= '0;
      r_src      <= '0;
      r_pc       <= '0;
      r_rd_data  <= '0;
      r_redir_pc <= '0;
      r_redir    <= 1'b0;
`ifdef CSR_TRAP_MSTATUS_EN
      r_pend_pc  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op  <= io_dec.req_op;
        r_csr <= io_dec.req_csr;
        r_src <= io_dec.req_src;
        r_pc  <= io_dec.req_pc;
      end
      // Results only change on entry to DONE, so they stay stable between completions.
      if (w_state_nxt == ST_DONE) begin
        r_rd_data  <= w_res_rd;
        r_redir_pc <= w_res_pc;
        r_redir    <= w_res_redir;
      end
`ifdef CSR_TRAP_MSTATUS_EN
      if ((r_state == ST_TRAP) || (r_state == ST_MRET)) r_pend_pc <= w_res_pc;
`endif
    end
  end

endmodule
